// File: rtl/chopper_pkg.sv
// rtl/chopper_pkg.sv - shared state encoding and default timer width for the coil chopper
package chopper_pkg;

  localparam int CHOP_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2,
    OFF   = 2'd3
  } chop_state_e;

endpackage

// File: rtl/chop_timer.sv
// rtl/chop_timer.sv - loadable down-counter that saturates at zero
module chop_timer
  import chopper_pkg::*;
#(
  parameter int WIDTH = CHOP_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

endmodule

// File: rtl/chopper_sequencer.sv
// rtl/chopper_sequencer.sv - blank / on / off-decay sequencing for one coil's current chopper
// All phases share one timer; each transition loads the target phase's duration.
module chopper_sequencer
  import chopper_pkg::*;
#(
  parameter int WIDTH = CHOP_WIDTH
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic [WIDTH-1:0] blank_time,
  input  logic [WIDTH-1:0] max_on_time,
  input  logic [WIDTH-1:0] off_time,
  input  logic             overcurrent,
  output logic             drive_on,
  output logic             blanking,
  output logic             decay,
  output logic             oc_trip,
  output logic             on_timeout,
  output logic [1:0]       state
);

  chop_state_e      state_q, state_d;
  logic             oc_meta, oc_s;
  logic [WIDTH-1:0] blank_sh, on_sh, off_sh;
  logic             tmr_load;
  logic [WIDTH-1:0] tmr_value, tmr_count;
  logic             tmr_zero;
  logic             latch_en;
  logic             trip_d, tout_d;

  chop_timer #(.WIDTH(WIDTH)) u_timer (
    .clk        (clk),
    .resetn     (resetn),
    .load       (tmr_load),
    .load_value (tmr_value),
    .count      (tmr_count)
  );

  assign tmr_zero = (tmr_count == '0);
  assign state    = state_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      oc_meta <= 1'b0;
      oc_s    <= 1'b0;
    end else begin
      oc_meta <= overcurrent;
      oc_s    <= oc_meta;
    end
  end

  // Entering BLANK loads the live blank_time, since the shadow copy is captured on the same edge.
  always_comb begin
    state_d   = state_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    latch_en  = 1'b0;
    trip_d    = 1'b0;
    tout_d    = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = BLANK;
          tmr_load  = 1'b1;
          tmr_value = blank_time;
          latch_en  = 1'b1;
        end
        BLANK: begin
          if (tmr_zero) begin
            state_d   = ON;
            tmr_load  = 1'b1;
            tmr_value = on_sh;
          end
        end
        ON: begin
          if (oc_s) begin
            state_d   = OFF;
            tmr_load  = 1'b1;
            tmr_value = off_sh;
            trip_d    = 1'b1;
          end else if (tmr_zero) begin
            state_d   = OFF;
            tmr_load  = 1'b1;
            tmr_value = off_sh;
            tout_d    = 1'b1;
          end
        end
        OFF: begin
          if (tmr_zero) begin
            state_d   = BLANK;
            tmr_load  = 1'b1;
            tmr_value = blank_time;
            latch_en  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      blank_sh <= '0;
      on_sh    <= '0;
      off_sh   <= '0;
    end else begin
      state_q <= state_d;
      if (latch_en) begin
        blank_sh <= blank_time;
        on_sh    <= max_on_time;
        off_sh   <= off_time;
      end
    end
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      drive_on   <= 1'b0;
      blanking   <= 1'b0;
      decay      <= 1'b0;
      oc_trip    <= 1'b0;
      on_timeout <= 1'b0;
    end else begin
      drive_on   <= (state_d == BLANK) || (state_d == ON);
      blanking   <= (state_d == BLANK);
      decay      <= (state_d == OFF);
      oc_trip    <= trip_d;
      on_timeout <= tout_d;
    end
  end

endmodule
